// File: rtl/channel_receiver.sv
// channel_receiver: four-phase handshake receiver driving two saturating level registers.
// Asynchronous up/down requests are synchronized and edge-detected.
// Each detected request runs through the IDLE -> APPLY -> ACK handshake.
module channel_receiver #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LEVEL_MAX  = 255,
    parameter int unsigned LEVEL_INIT = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Ch1_up,
    input  logic             Ch1_down,
    input  logic             Ch2_up,
    input  logic             Ch2_down,
    output logic [WIDTH-1:0] Ch1_level,
    output logic [WIDTH-1:0] Ch2_level,
    output logic             Ack,
    output logic             Busy,
    output logic             Error
);

    localparam logic [WIDTH-1:0] LVL_MAX  = WIDTH'(LEVEL_MAX);
    localparam logic [WIDTH-1:0] LVL_INIT = WIDTH'(LEVEL_INIT);
    localparam logic [WIDTH-1:0] LVL_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] LVL_ZERO = WIDTH'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    // Bit order everywhere: {ch2_down, ch2_up, ch1_down, ch1_up}
    logic [3:0] req_raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] hist;
    logic [3:0] cmd;
    logic       seen;
    logic       cmd_legal;
    state_t     state;

    assign req_raw   = {Ch2_down, Ch2_up, Ch1_down, Ch1_up};
    assign seen      = |(sync2 & ~hist);
    // Legal means exactly one request bit set
    assign cmd_legal = (cmd != 4'd0) && ((cmd & (cmd - 4'd1)) == 4'd0);

    // Two-flop synchronizer followed by a history flop for rising-edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 4'd0;
            sync2 <= 4'd0;
            hist  <= 4'd0;
        end else begin
            sync1 <= req_raw;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Handshake FSM with registered levels, Ack, Busy and sticky Error
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cmd       <= 4'd0;
            Ch1_level <= LVL_INIT;
            Ch2_level <= LVL_INIT;
            Ack       <= 1'b0;
            Busy      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seen) begin
                        state <= APPLY;
                        cmd   <= sync2;
                        Busy  <= 1'b1;
                    end
                end
                APPLY: begin
                    state <= ACK;
                    Ack   <= 1'b1;
                    if (cmd_legal) begin
                        if (cmd[0] && (Ch1_level < LVL_MAX))  Ch1_level <= Ch1_level + LVL_ONE;
                        if (cmd[1] && (Ch1_level > LVL_ZERO)) Ch1_level <= Ch1_level - LVL_ONE;
                        if (cmd[2] && (Ch2_level < LVL_MAX))  Ch2_level <= Ch2_level + LVL_ONE;
                        if (cmd[3] && (Ch2_level > LVL_ZERO)) Ch2_level <= Ch2_level - LVL_ONE;
                    end else begin
                        Error <= 1'b1;
                    end
                end
                ACK: begin
                    // Sender must drop every request line before the next command
                    if (sync2 == 4'd0) begin
                        state <= IDLE;
                        Ack   <= 1'b0;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Ack   <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
